// File: rtl/unidad_control_bip_if.sv
// Bus between the BIP control unit (master) and its ROM/datapath (slave).
// Enable is a level run request; the master samples it only while fetching, with no back-pressure.
interface unidad_control_bip_if #(
    parameter int PC_WIDTH   = 11,
    parameter int DATA_WIDTH = 16
);
    logic                  Enable;
    logic [DATA_WIDTH-1:0] PmData;
    logic [PC_WIDTH-1:0]   PmAddr;
    logic [PC_WIDTH-1:0]   RamAddr;
    logic [DATA_WIDTH-1:0] Operando;
    logic [1:0]            SelA;
    logic                  SelB;
    logic                  WrAcc;
    logic                  Op;
    logic                  WrRam;
    logic                  RdRam;
    logic                  Halt;
    // Debug view of the sequencer: 0 FETCH, 1 DECODE, 2 EXEC, 3 HALT
    logic [1:0]            dbg_state;

    modport master (
        input  Enable, PmData,
        output PmAddr, RamAddr, Operando, SelA, SelB, WrAcc, Op, WrRam, RdRam, Halt, dbg_state
    );

    modport slave (
        output Enable, PmData,
        input  PmAddr, RamAddr, Operando, SelA, SelB, WrAcc, Op, WrRam, RdRam, Halt, dbg_state
    );
endinterface

// File: rtl/unidad_control_bip.sv
// Control unit of the 16-bit BIP accumulator machine: FETCH/DECODE/EXEC sequencer with HALT.
// Optional macro UC_INSTR_COUNT_EN adds a saturating executed-instruction counter (InstrCount).
module unidad_control_bip #(
    parameter int PC_WIDTH   = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    unidad_control_bip_if.master        bus
`ifdef UC_INSTR_COUNT_EN
    ,
    output logic [15:0]                 InstrCount
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    // Only the operand field of the instruction is kept; the opcode is consumed at decode.
    logic [PC_WIDTH-1:0] ir_q, ir_d;
    logic [1:0]          sel_a_q, sel_a_d;
    logic                sel_b_q, sel_b_d;
    logic                op_q, op_d;
    logic                wr_acc_q, wr_acc_d;
    logic                wr_ram_q, wr_ram_d;
    logic                rd_ram_q, rd_ram_d;
    logic                halt_q, halt_d;
    logic [4:0]          opcode;

    assign opcode = bus.PmData[DATA_WIDTH-1 -: 5];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            sel_a_q  <= 2'b00;
            sel_b_q  <= 1'b0;
            op_q     <= 1'b0;
            wr_acc_q <= 1'b0;
            wr_ram_q <= 1'b0;
            rd_ram_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            op_q     <= op_d;
            wr_acc_q <= wr_acc_d;
            wr_ram_q <= wr_ram_d;
            rd_ram_q <= rd_ram_d;
            halt_q   <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.Enable) state_d = S_DECODE;
            S_DECODE: state_d = (opcode == 5'b00000) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Controls are registered at the DECODE edge and cleared at the EXEC edge,
    // so they are live for exactly the EXEC cycle.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        sel_a_d  = 2'b00;
        sel_b_d  = 1'b0;
        op_d     = 1'b0;
        wr_acc_d = 1'b0;
        wr_ram_d = 1'b0;
        rd_ram_d = 1'b0;
        halt_d   = halt_q;
        case (state_q)
            S_DECODE: begin
                ir_d = bus.PmData[PC_WIDTH-1:0];
                if (opcode == 5'b00000) halt_d = 1'b1;
                case (opcode)
                    5'b00001: wr_ram_d = 1'b1;
                    5'b00010: begin rd_ram_d = 1'b1; wr_acc_d = 1'b1; end
                    5'b00011: begin wr_acc_d = 1'b1; sel_a_d = 2'b01; end
                    5'b00100: begin rd_ram_d = 1'b1; wr_acc_d = 1'b1; sel_a_d = 2'b10; end
                    5'b00101: begin wr_acc_d = 1'b1; sel_a_d = 2'b10; sel_b_d = 1'b1; end
                    5'b00110: begin rd_ram_d = 1'b1; wr_acc_d = 1'b1; sel_a_d = 2'b10; op_d = 1'b1; end
                    5'b00111: begin wr_acc_d = 1'b1; sel_a_d = 2'b10; sel_b_d = 1'b1; op_d = 1'b1; end
                    default:  ;
                endcase
            end
            S_EXEC:  pc_d = pc_q + 1'b1;
            default: ;
        endcase
    end

`ifdef UC_INSTR_COUNT_EN
    logic [15:0] instr_count_q, instr_count_d;

    always_comb begin
        instr_count_d = instr_count_q;
        if (state_q == S_EXEC && instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) instr_count_q <= 16'd0;
        else     instr_count_q <= instr_count_d;
    end

    assign InstrCount = instr_count_q;
`endif

    assign bus.PmAddr    = pc_q;
    assign bus.RamAddr   = ir_q;
    assign bus.Operando  = {{(DATA_WIDTH-PC_WIDTH){ir_q[PC_WIDTH-1]}}, ir_q};
    assign bus.SelA      = sel_a_q;
    assign bus.SelB      = sel_b_q;
    assign bus.Op        = op_q;
    assign bus.WrAcc     = wr_acc_q;
    assign bus.WrRam     = wr_ram_q;
    assign bus.RdRam     = rd_ram_q;
    assign bus.Halt      = halt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_unidad_control_bip.sv
// Bench for unidad_control_bip: vector table, randomized program, halt/wrap/reset corner cases.
// Build with UC_INSTR_COUNT_EN defined to also check InstrCount.
module tb_unidad_control_bip;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    unidad_control_bip_if #(.PC_WIDTH(11), .DATA_WIDTH(16)) bus ();

`ifdef UC_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    unidad_control_bip #(.PC_WIDTH(11), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef UC_INSTR_COUNT_EN
        ,
        .InstrCount (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM
    logic [15:0] rom [2048];
    always @(posedge clk) bus.PmData <= rom[bus.PmAddr];

    typedef struct {
        logic [15:0] instr;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        wr_acc;
        logic        wr_ram;
        logic        rd_ram;
    } vec_t;

    vec_t vecs [9];
    int   exp_count;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected controls from the instruction-set rules
    function automatic vec_t model(input logic [15:0] instr);
        vec_t e;
        int   opc;
        bit   alu;
        opc      = int'(instr[15:11]);
        alu      = (opc >= 4 && opc <= 7);
        e.instr  = instr;
        e.wr_ram = (opc == 1);
        e.wr_acc = (opc >= 2 && opc <= 7);
        e.rd_ram = (opc == 2 || opc == 4 || opc == 6);
        e.sel_a  = alu ? 2'd2 : ((opc == 3) ? 2'd1 : 2'd0);
        e.sel_b  = alu && (opc % 2 == 1);
        e.op     = (opc == 6 || opc == 7);
        return e;
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] instr);
        int v;
        v = int'(instr[10:0]);
        if (v >= 1024) v = v - 2048;
        return v[15:0];
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        bus.Enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_count = 0;
    endtask

    // Called at a negedge inside FETCH with the PC expected at pc.
    task automatic exec_one(input vec_t e, input int pc, input int idle);
        check("fetch_pmaddr", {5'd0, bus.PmAddr}, pc[15:0]);
        check("fetch_strobes", {13'd0, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        bus.Enable = 1'b0;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            check("idle_pmaddr", {5'd0, bus.PmAddr}, pc[15:0]);
            check("idle_strobes", {13'd0, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        end
        bus.Enable = 1'b1;
        @(negedge clk);
        check("decode_strobes", {13'd0, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        @(negedge clk);
        check("exec_wr_acc", {15'd0, bus.WrAcc}, {15'd0, e.wr_acc});
        check("exec_wr_ram", {15'd0, bus.WrRam}, {15'd0, e.wr_ram});
        check("exec_rd_ram", {15'd0, bus.RdRam}, {15'd0, e.rd_ram});
        check("exec_sel_a", {14'd0, bus.SelA}, {14'd0, e.sel_a});
        check("exec_sel_b", {15'd0, bus.SelB}, {15'd0, e.sel_b});
        check("exec_op", {15'd0, bus.Op}, {15'd0, e.op});
        check("exec_ram_addr", {5'd0, bus.RamAddr}, {5'd0, e.instr[10:0]});
        check("exec_operando", bus.Operando, sext(e.instr));
        @(negedge clk);
        exp_count++;
        check("post_ctrl", {10'd0, bus.SelA, bus.SelB, bus.Op, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        check("post_pmaddr", {5'd0, bus.PmAddr}, 16'((pc + 1) % 2048));
    endtask

    task automatic check_count();
`ifdef UC_INSTR_COUNT_EN
        check("instr_count", instr_count, 16'(exp_count));
`endif
    endtask

    task automatic run_halt(input int pc);
        check("hlt_fetch_pmaddr", {5'd0, bus.PmAddr}, pc[15:0]);
        bus.Enable = 1'b1;
        @(negedge clk);
        check("hlt_decode_halt", {15'd0, bus.Halt}, 16'd0);
        @(negedge clk);
        check("hlt_halt_set", {15'd0, bus.Halt}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            bus.Enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_pmaddr", {5'd0, bus.PmAddr}, pc[15:0]);
            check("halt_level", {15'd0, bus.Halt}, 16'd1);
            check("halt_strobes", {13'd0, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        end
        check_count();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{16'h1805, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'h2FFF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0803, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h3003, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h1007, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h2005, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h3C00, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h4123, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'hF800, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;

        // Reset state
        rst        = 1'b1;
        bus.Enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pmaddr", {5'd0, bus.PmAddr}, 16'd0);
        check("rst_ctrl", {10'd0, bus.SelA, bus.SelB, bus.Op, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        check("rst_halt", {15'd0, bus.Halt}, 16'd0);
        check("rst_operando", bus.Operando, 16'd0);
        check("rst_ram_addr", {5'd0, bus.RamAddr}, 16'd0);
        check("rst_state", {14'd0, bus.dbg_state}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        exp_count = 0;
        check_count();

        // Reference program: LDI 5, ADDI -1, STO 3, SUB 3, HLT; with a 5-cycle Enable gap first
        for (int i = 0; i < 4; i++) rom[i] = vecs[i].instr;
        rom[4] = 16'h0000;
        for (int i = 0; i < 4; i++) exec_one(vecs[i], i, (i == 0) ? 5 : 0);
        run_halt(4);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clears_halt", {15'd0, bus.Halt}, 16'd0);
        check("rst_clears_pc", {5'd0, bus.PmAddr}, 16'd0);

        // Full vector table followed by a randomized program
        for (int i = 0; i < 9; i++) rom[i] = vecs[i].instr;
        for (int i = 9; i < 49; i++) begin
            logic [15:0] w;
            w = 16'($urandom_range(0, 16'hFFFF));
            if (w[15:11] == 5'd0) w[11] = 1'b1;
            rom[i] = w;
        end
        rom[49] = 16'h0000;
        do_reset();
        for (int i = 0; i < 9; i++) exec_one(vecs[i], i, (i == 4) ? 5 : 0);
        for (int i = 9; i < 49; i++) exec_one(model(rom[i]), i, $urandom_range(0, 2));
        run_halt(49);

        // PC wrap: 2047 NOPs bring PC to the top, one more wraps it to 0
        for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;
        do_reset();
        bus.Enable = 1'b1;
        repeat (3 * 2047) @(negedge clk);
        exp_count = 2047;
        check("wrap_top_pc", {5'd0, bus.PmAddr}, 16'd2047);
        exec_one(model(16'h4000), 2047, 0);
        check_count();

        // Reset in the middle of EXEC
        rom[0] = 16'h1805;
        do_reset();
        bus.Enable = 1'b1;
        repeat (2) @(negedge clk);
        check("midexec_wr_acc", {15'd0, bus.WrAcc}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midexec_rst_ctrl", {10'd0, bus.SelA, bus.SelB, bus.Op, bus.WrAcc, bus.WrRam, bus.RdRam}, 16'd0);
        check("midexec_rst_pc", {5'd0, bus.PmAddr}, 16'd0);
        check("midexec_rst_state", {14'd0, bus.dbg_state}, 16'd0);
        rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check_count();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
